// File: rtl/byte_pixel_sequencer_pkg.sv
// Shared constants and helpers for the byte-to-pixel packing path.
package byte_pixel_sequencer_pkg;

    localparam int unsigned PIX_W         = 24;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned BYTES_PER_PIX = 3;

    // 1080p active-video defaults
    localparam int unsigned DEF_H_ACTIVE  = 1920;
    localparam int unsigned DEF_V_ACTIVE  = 1080;
    localparam int unsigned DEF_HCNT_W    = 12;
    localparam int unsigned DEF_VCNT_W    = 11;

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_PIX - 1);

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Pixel/line position tracker: advances on each accepted pixel and flags
// first-of-frame, last-of-line and end-of-frame.
module video_pos_counter
    import byte_pixel_sequencer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned HCNT_W   = DEF_HCNT_W,
    parameter int unsigned VCNT_W   = DEF_VCNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic advance_i,
    output logic sof_o,
    output logic eol_o,
    output logic frame_done_o
);

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_ACTIVE - 1);

    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;

    assign sof_o        = (hcnt_q == '0) & (vcnt_q == '0);
    assign eol_o        = (hcnt_q == H_LAST);
    assign frame_done_o = advance_i & eol_o & (vcnt_q == V_LAST);

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (clear_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (advance_i) begin
            if (eol_o) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCNT_W'(1);
            end else begin
                hcnt_d = hcnt_q + HCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

endmodule

// File: rtl/byte_pixel_sequencer.sv
// Drains the byte FIFO, packs three bytes (LSB first) into a 24-bit pixel and
// presents it on a valid/ready port tagged with sof/eol.
module byte_pixel_sequencer
    import byte_pixel_sequencer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned HCNT_W   = DEF_HCNT_W,
    parameter int unsigned VCNT_W   = DEF_VCNT_W
) (
    input  logic              tx_clock,
    input  logic              tx_rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    output logic              fifo_rd_ena,
    input  logic [BYTE_W-1:0] fifo_dout,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              frame_done,
    output logic              busy
);

    logic [1:0]          rd_idx_q, rd_idx_d;
    logic                arr_vld_q, arr_vld_d;
    logic [1:0]          arr_idx_q, arr_idx_d;
    logic [2*BYTE_W-1:0] acc_q, acc_d;
    logic [PIX_W-1:0]    pix_data_q, pix_data_d;
    logic                pix_valid_q, pix_valid_d;
    logic                handshake, load, sof, eol;

    // The last byte of a pixel is only read once the output register is
    // guaranteed free by the time it lands.
    assign fifo_rd_ena = tx_rst_n & enable & ~fifo_empty & ~flush &
                         ((rd_idx_q != IDX_LAST) | ~pix_valid_q | pix_ready);
    assign handshake   = pix_valid_q & pix_ready;
    assign load        = arr_vld_q & (arr_idx_q == IDX_LAST) & ~flush;

    always_comb begin
        rd_idx_d    = fifo_rd_ena ? next_idx(rd_idx_q) : rd_idx_q;
        arr_vld_d   = fifo_rd_ena;
        arr_idx_d   = rd_idx_q;
        acc_d       = acc_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        if (flush) begin
            rd_idx_d    = '0;
            acc_d       = '0;
            pix_data_d  = '0;
            pix_valid_d = 1'b0;
        end else begin
            if (arr_vld_q) begin
                case (arr_idx_q)
                    2'd0:    acc_d[BYTE_W-1:0]        = fifo_dout;
                    2'd1:    acc_d[2*BYTE_W-1:BYTE_W] = fifo_dout;
                    default: ;
                endcase
            end
            if (load) begin
                pix_data_d  = {fifo_dout, acc_q};
                pix_valid_d = 1'b1;
            end else if (handshake) begin
                pix_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge tx_clock or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            rd_idx_q    <= '0;
            arr_vld_q   <= 1'b0;
            arr_idx_q   <= '0;
            acc_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            rd_idx_q    <= rd_idx_d;
            arr_vld_q   <= arr_vld_d;
            arr_idx_q   <= arr_idx_d;
            acc_q       <= acc_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    video_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .HCNT_W   (HCNT_W),
        .VCNT_W   (VCNT_W)
    ) u_pos (
        .clk_i        (tx_clock),
        .rst_ni       (tx_rst_n),
        .clear_i      (flush),
        .advance_i    (handshake),
        .sof_o        (sof),
        .eol_o        (eol),
        .frame_done_o (frame_done)
    );

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_sof   = pix_valid_q & sof;
    assign pix_eol   = pix_valid_q & eol;
    assign busy      = (rd_idx_q != 2'd0) | arr_vld_q | pix_valid_q;

    load_into_free_reg: assert property (@(posedge tx_clock) disable iff (!tx_rst_n)
        load |-> !pix_valid_q);
    no_read_when_empty: assert property (@(posedge tx_clock) disable iff (!tx_rst_n)
        fifo_rd_ena |-> !fifo_empty);

endmodule

// File: tb/tb_byte_pixel_sequencer.sv
// Bench for byte_pixel_sequencer: FIFO model, pixel-stream scoreboard and
// directed scenarios on a 4x2 frame.
module tb_byte_pixel_sequencer;

    localparam int H_T   = 4;
    localparam int V_T   = 2;
    localparam int FRAME = H_T * V_T;

    logic        tx_clock = 1'b0;
    logic        tx_rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        flush = 1'b0;
    logic        pix_ready = 1'b1;
    logic        force_empty = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_ena;
    logic [7:0]  fifo_dout = 8'h00;
    logic [23:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol, frame_done, busy;

    logic [7:0]  mem [4096];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [23:0] data;
        int          rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  part_q[$];
    int          pix_no = 0;
    int          cyc = 0;
    int          hs_count = 0;
    logic [23:0] log_data [1024];
    logic        log_sof [1024];
    logic        log_eol [1024];
    logic        log_fd [1024];
    logic        pv_exp, hs;

    byte_pixel_sequencer #(
        .H_ACTIVE (H_T),
        .V_ACTIVE (V_T),
        .HCNT_W   (12),
        .VCNT_W   (11)
    ) dut (
        .tx_clock    (tx_clock),
        .tx_rst_n    (tx_rst_n),
        .enable      (enable),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .fifo_rd_ena (fifo_rd_ena),
        .fifo_dout   (fifo_dout),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 tx_clock = ~tx_clock;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    // Byte FIFO: one-cycle read latency, emptied by reset.
    always @(posedge tx_clock) begin
        if (!tx_rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_ena) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: bytes read are grouped in threes; each pixel is due two
    // cycles after its last read and delivered in order; tags follow pixel count.
    always @(negedge tx_clock) begin
        if (!tx_rst_n) begin
            chk("reset_outputs", 32'({fifo_rd_ena, pix_data, pix_valid, pix_sof, pix_eol,
                                      frame_done, busy}), 32'h0);
            exp_q.delete();
            part_q.delete();
            pix_no = 0;
        end else begin
            pv_exp = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
            hs     = pix_valid && pix_ready;
            chk("pix_valid", 32'(pix_valid), 32'(pv_exp));
            if (pix_valid && pv_exp) begin
                chk("pix_data", 32'(pix_data), 32'(exp_q[0].data));
                chk("pix_sof", 32'(pix_sof), 32'(pix_no % FRAME == 0));
                chk("pix_eol", 32'(pix_eol), 32'(pix_no % H_T == H_T - 1));
            end
            chk("frame_done", 32'(frame_done), 32'(hs && pv_exp && (pix_no % FRAME == FRAME - 1)));
            chk("busy", 32'(busy), 32'((part_q.size() > 0) || (exp_q.size() > 0)));
            chk("read_legal", 32'(fifo_rd_ena && (fifo_empty || !enable || flush)), 32'h0);
            if (flush) begin
                exp_q.delete();
                part_q.delete();
                pix_no = 0;
            end else begin
                if (hs) begin
                    if (hs_count < 1024) begin
                        log_data[hs_count] = pix_data;
                        log_sof[hs_count]  = pix_sof;
                        log_eol[hs_count]  = pix_eol;
                        log_fd[hs_count]   = frame_done;
                    end
                    hs_count++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    pix_no++;
                end
                if (fifo_rd_ena) begin
                    part_q.push_back(mem[rd_ptr]);
                    if (part_q.size() == 3) begin
                        exp_q.push_back('{data: {part_q[2], part_q[1], part_q[0]}, rdy: cyc + 2});
                        part_q.delete();
                    end
                end
            end
        end
        cyc++;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge tx_clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge tx_clock);
            n++;
        end while ((busy || fifo_rd_ena || !fifo_empty) && n < 500);
        chk({name, "_idle"}, 32'(busy || fifo_rd_ena || !fifo_empty), 32'h0);
    endtask

    initial begin
        int k, nr;
        logic [8:0] sof_tab, eol_tab, fd_tab;

        // Reset, then a mid-stream reset, then the first pixel restarts at sof.
        repeat (3) tick();
        tx_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) push(8'(i + 1));
        repeat (5) tick();
        tx_rst_n = 1'b0;
        repeat (3) tick();
        tx_rst_n = 1'b1;
        tick();
        k = hs_count;
        push(8'h11); push(8'h22); push(8'h33);
        wait_idle("first");
        chk("first_count", 32'(hs_count - k), 32'd1);
        chk("first_data", 32'(log_data[k]), 32'h332211);
        chk("first_sof", 32'(log_sof[k]), 32'd1);

        // Streaming: 300 back-to-back reads.
        tick();
        k  = hs_count;
        nr = 0;
        for (int i = 0; i < 300; i++) push(8'(i * 7 + 3));
        for (int i = 0; i < 300; i++) begin
            @(negedge tx_clock);
            if (fifo_rd_ena) nr++;
        end
        chk("stream_reads", 32'(nr), 32'd300);
        @(negedge tx_clock);
        chk("stream_stop", 32'(fifo_rd_ena), 32'd0);
        wait_idle("stream");
        chk("stream_pixels", 32'(hs_count - k), 32'd100);

        // Backpressure: first pixel stalls, only two more reads go out.
        tick();
        k         = hs_count;
        nr        = 0;
        pix_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(8'(8'h40 + i));
        for (int i = 0; i < 15; i++) begin
            @(negedge tx_clock);
            if (fifo_rd_ena) nr++;
        end
        chk("bp_reads", 32'(nr), 32'd5);
        chk("bp_rd_stopped", 32'(fifo_rd_ena), 32'd0);
        chk("bp_held", 32'(pix_valid), 32'd1);
        tick();
        pix_ready = 1'b1;
        wait_idle("bp");
        chk("bp_pixels", 32'(hs_count - k), 32'd4);

        // Line/frame tags over 9 pixels after a flush.
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        k = hs_count;
        for (int i = 0; i < 27; i++) push(8'(8'h80 + i));
        wait_idle("tags");
        chk("tags_pixels", 32'(hs_count - k), 32'd9);
        sof_tab = 9'b1_0000_0001;
        eol_tab = 9'b0_1000_1000;
        fd_tab  = 9'b0_1000_0000;
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("tag_sof%0d", j), 32'(log_sof[k + j]), 32'(sof_tab[j]));
            chk($sformatf("tag_eol%0d", j), 32'(log_eol[k + j]), 32'(eol_tab[j]));
            chk($sformatf("tag_fd%0d", j), 32'(log_fd[k + j]), 32'(fd_tab[j]));
        end

        // Empty gaps every other cycle, enable dropped after the fourth read.
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        k  = hs_count;
        nr = 0;
        force_empty = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'hA1 + i));
        for (int i = 0; i < 40 && nr < 4; i++) begin
            tick();
            force_empty = ~force_empty;
            @(negedge tx_clock);
            if (fifo_rd_ena) nr++;
        end
        tick();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge tx_clock);
            if (fifo_rd_ena) nr++;
            tick();
            force_empty = ~force_empty;
        end
        chk("gap_reads", 32'(nr), 32'd4);
        chk("gap_pixels", 32'(hs_count - k), 32'd1);
        chk("gap_data", 32'(log_data[k]), 32'hA3A2A1);
        chk("gap_busy_held", 32'(busy), 32'd1);
        enable      = 1'b1;
        force_empty = 1'b0;
        wait_idle("gap");
        chk("gap_resume_pixels", 32'(hs_count - k), 32'd2);
        chk("gap_resume_data", 32'(log_data[k + 1]), 32'hA6A5A4);

        // Flush with two bytes held and the third in flight.
        tick();
        k = hs_count;
        push(8'hD1); push(8'hD2); push(8'hD3);
        repeat (3) @(posedge tx_clock);
        #1 flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) @(negedge tx_clock);
        chk("flush_dropped", 32'(hs_count - k), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        tick();
        push(8'hE1); push(8'hE2); push(8'hE3);
        wait_idle("flush");
        chk("flush_next_data", 32'(log_data[k]), 32'hE3E2E1);
        chk("flush_next_sof", 32'(log_sof[k]), 32'd1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/byte_pixel_sequencer.md
Name: byte_pixel_sequencer

Overview:
- Read-side controller for the second width-conversion stage in the 250 MHz tx domain.
- Drains 8-bit bytes from the byte FIFO and packs every 3 bytes into one 24-bit pixel.
- Presents pixels on a valid/ready interface.
- Tags pixels with start-of-frame and end-of-line markers from programmable active-video dimensions.
- Sustains 1 byte per cycle when the FIFO is non-empty and the sink is ready.

Parameters:
- H_ACTIVE, 1920, pixels per line.
- V_ACTIVE, 1080, lines per frame.
- HCNT_W, 12, pixel counter width; must satisfy 2^HCNT_W > H_ACTIVE.
- VCNT_W, 11, line counter width; must satisfy 2^VCNT_W > V_ACTIVE.

Ports:
- tx_clock  in  1  single clock, 250 MHz.
- tx_rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new FIFO reads.
- flush  in  1  synchronous clear of partial pixel and counters.
- fifo_empty  in  1  byte FIFO empty.
- fifo_rd_ena  out  1  byte FIFO read request; data returns the next cycle.
- fifo_dout  in  8  FIFO read data, valid 1 cycle after fifo_rd_ena.
- pix_data  out  24  packed pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts pixel.
- pix_sof  out  1  qualifies pix_data: first pixel of frame.
- pix_eol  out  1  qualifies pix_data: last pixel of line.
- frame_done  out  1  one-cycle pulse on handshake of the last pixel of a frame.
- busy  out  1  partial pixel held, read in flight, or pix_valid high.

Behaviour:
- Reset: all outputs are 0; byte index, counters and in-flight flag are cleared; any returning FIFO byte is discarded.
- Read issue: fifo_rd_ena = enable & !fifo_empty & !flush & (rd_idx != 2 | !pix_valid | pix_ready).
  - This is a combinational path from pix_ready.
- rd_idx (0..2) is the byte position of the next read. It increments mod 3 on each issued read.
- Arrival: a 1-cycle delayed copy of fifo_rd_ena and rd_idx qualifies fifo_dout.
  - idx0 → bits [7:0], idx1 → [15:8], idx2 → [23:16]. The first byte read is the LSB.
- Pixel load: when an idx2 byte arrives, pix_data is loaded with {byte2, acc[15:0]} and pix_valid is set.
  - The issue rule guarantees the output register is free at that cycle. No overwrite is possible; this is an assertion target.
- pix_valid clears on handshake (pix_valid & pix_ready) unless a load happens in the same cycle.
  - Loads are spaced at least 3 cycles apart, so handshake and load never coincide. Assert it.
- Latency: third byte read at cycle t → pix_valid at t+2.
- pix_sof / pix_eol / frame_done are derived from counters hcnt and vcnt that advance on each handshake.
  - pix_sof = (hcnt==0 & vcnt==0).
  - pix_eol = (hcnt==H_ACTIVE-1).
  - hcnt wraps to 0 at H_ACTIVE-1 and vcnt increments.
  - vcnt wraps to 0 at V_ACTIVE-1 on the eol handshake; frame_done pulses that cycle.
- enable low: no new reads are issued. An in-flight byte still lands. The partial pixel and pix_valid are held, and the output may still handshake.
- flush: in the same cycle, rd_idx, accumulator, counters and pix_valid go to 0. A byte arriving in the flush cycle or the next cycle is dropped.
- fifo_empty mid-pixel: reads pause and the partial bytes are held indefinitely.
- Sink stall: at most 2 further reads (idx0, idx1) are issued, then reads stop until pix_ready.
- Asynchronous reset mid-frame: immediate clear. The next frame restarts at sof.
- The FIFO is never read while empty.

Decomposition:
- Shared package: PIX_W=24, BYTE_W=8, BYTES_PER_PIX=3, and default H_ACTIVE/V_ACTIVE for 1080p.
- One natural sub-module: video_pos_counter (hcnt/vcnt, sof/eol/frame_done), reusable by the downstream timing generator.

Test Plan:
- Reset: assert tx_rst_n=0 mid-stream → all outputs 0; after release, first pixel from bytes 0x11,0x22,0x33 gives pix_data=0x332211 with pix_sof=1.
- Streaming: FIFO holds 300 bytes, pix_ready=1 → fifo_rd_ena high 300 consecutive cycles; 100 pixels, each valid 2 cycles after its third read; no bubbles.
- Backpressure: pix_ready=0 for 10 cycles after first pixel → exactly 2 extra reads, then fifo_rd_ena=0; on ready, pixel 2 appears 2 cycles after its third read.
- Line/frame tags (H_ACTIVE=4, V_ACTIVE=2): 8 pixels → pix_eol on pixels 3 and 7, pix_sof on pixel 0 only, frame_done pulse on pixel 7 handshake, next pixel sof=1.
- Empty gaps and enable: fifo_empty toggled every other byte, enable dropped after byte 4 → no read while empty or disabled; 1 pixel out, 1 byte held; resumes correctly.
- Flush: flush with 2 bytes held and 1 in flight → arriving byte dropped, counters 0; next 3 bytes form a pixel with pix_sof=1.
